// File: rtl/wch_fht_param.sv
// Iterative N-point fast Walsh-Hadamard transform with natural (Sylvester) output order.
// One perfect-shuffle butterfly stage per clock, optional 1/N scaling for the inverse.
module wch_fht_param #(
    parameter int unsigned LOG2N = 4,
    parameter int unsigned IW    = 12,
    localparam int unsigned N    = 1 << LOG2N,
    localparam int unsigned OW   = IW + LOG2N
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Inverse,
    input  logic [N*IW-1:0] InBus,
    output logic            Busy,
    output logic            Done,
    output logic            StartErr,
    output logic [N*OW-1:0] OutBus
);

    localparam int unsigned CW = $clog2(LOG2N + 1);

    logic [N*OW-1:0] work_q, work_d;
    logic [N*OW-1:0] out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            start_err_q, start_err_d;
    logic            inv_q, inv_d;

    logic [N*OW-1:0] in_ext;
    logic [N*OW-1:0] in_stage;
    logic [N*OW-1:0] work_stage;
    logic [N*OW-1:0] work_scaled;

    // Perfect-shuffle butterfly; applying it LOG2N times yields Hadamard row order.
    function automatic logic [N*OW-1:0] butterfly(input logic [N*OW-1:0] t);
        logic [N*OW-1:0]     w;
        logic signed [OW-1:0] a;
        logic signed [OW-1:0] b;
        w = '0;
        for (int k = 0; k < int'(N / 2); k++) begin
            a = t[k*OW +: OW];
            b = t[(k + int'(N / 2))*OW +: OW];
            w[(2*k)*OW +: OW]   = a + b;
            w[(2*k+1)*OW +: OW] = a - b;
        end
        return w;
    endfunction

    always_comb begin
        in_ext      = '0;
        work_scaled = '0;
        for (int k = 0; k < int'(N); k++) begin
            in_ext[k*OW +: OW]      = OW'($signed(InBus[k*IW +: IW]));
            work_scaled[k*OW +: OW] = $signed(work_q[k*OW +: OW]) >>> LOG2N;
        end
        in_stage   = butterfly(in_ext);
        work_stage = butterfly(work_q);
    end

    always_comb begin
        work_d      = work_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        inv_d       = inv_q;
        // Uses registered busy so a Start in the Done cycle is a legal accept.
        start_err_d = Start & busy_q;
        if (!busy_q) begin
            if (Start) begin
                work_d = in_stage;
                inv_d  = Inverse;
                busy_d = 1'b1;
                cnt_d  = CW'(1);
            end
        end else if (cnt_q == CW'(LOG2N)) begin
            out_d  = inv_q ? work_scaled : work_q;
            done_d = 1'b1;
            busy_d = 1'b0;
            cnt_d  = '0;
        end else begin
            work_d = work_stage;
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            work_q      <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            work_q      <= work_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
            inv_q       <= inv_d;
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign StartErr = start_err_q;
    assign OutBus   = out_q;

endmodule

// File: tb/tb_wch_fht_param.sv
// Directed bench for wch_fht_param: a 4-point and a 16-point instance on a shared clock/reset.
module tb_wch_fht_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          s2, i2, busy2, done2, err2;
    logic [47:0]   in2;
    logic [55:0]   o2;
    logic          s4, i4, busy4, done4, err4;
    logic [191:0]  in4;
    logic [255:0]  o4;

    int n_cmp = 0;
    int n_bad = 0;

    wch_fht_param #(.LOG2N(2), .IW(12)) u_dut2 (
        .Clk(clk), .Reset(rst_n), .Start(s2), .Inverse(i2), .InBus(in2),
        .Busy(busy2), .Done(done2), .StartErr(err2), .OutBus(o2)
    );

    wch_fht_param #(.LOG2N(4), .IW(12)) u_dut4 (
        .Clk(clk), .Reset(rst_n), .Start(s4), .Inverse(i4), .InBus(in4),
        .Busy(busy4), .Done(done4), .StartErr(err4), .OutBus(o4)
    );

    typedef struct {
        logic         inv;
        logic [191:0] in_bus;
        logic [255:0] exp_bus;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] pk12(input int a[16]);
        logic [191:0] r;
        for (int j = 0; j < 16; j++) r[j*12 +: 12] = 12'(a[j]);
        return r;
    endfunction

    function automatic logic [255:0] pk16(input int e[16]);
        logic [255:0] r;
        for (int j = 0; j < 16; j++) r[j*16 +: 16] = 16'(e[j]);
        return r;
    endfunction

    task automatic start4(input logic inv, input logic [191:0] bus);
        @(negedge clk);
        s4 = 1'b1;
        i4 = inv;
        in4 = bus;
        @(posedge clk);
        #1;
        s4 = 1'b0;
        i4 = ~inv;
        in4 = {6{$urandom()}};
    endtask

    task automatic wait4(output int edges);
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (done4) break;
        end
    endtask

    initial begin
        int a[16];
        int e[16];
        int ed;
        int extra;
        logic [255:0] exp_ones;
        logic [255:0] exp_imp;
        logic [191:0] bus_ones;
        logic [191:0] bus_imp;

        rst_n = 1'b0;
        s2 = 1'b0; i2 = 1'b0; in2 = '0;
        s4 = 1'b0; i4 = 1'b0; in4 = '0;

        // Table: hand-computed Sylvester-order results
        for (int j = 0; j < 16; j++) begin a[j] = 1; e[j] = (j == 0) ? 16 : 0; end
        tbl[0] = '{1'b0, pk12(a), pk16(e)};
        bus_ones = pk12(a);
        exp_ones = pk16(e);
        for (int j = 0; j < 16; j++) begin a[j] = (j == 0) ? -5 : 0; e[j] = -5; end
        tbl[1] = '{1'b0, pk12(a), pk16(e)};
        bus_imp = pk12(a);
        exp_imp = pk16(e);
        for (int j = 0; j < 16; j++) begin a[j] = -2048; e[j] = (j == 0) ? -2048 : 0; end
        tbl[2] = '{1'b1, pk12(a), pk16(e)};
        for (int j = 0; j < 16; j++) begin a[j] = -2048; e[j] = (j == 0) ? -32768 : 0; end
        tbl[3] = '{1'b0, pk12(a), pk16(e)};
        for (int j = 0; j < 16; j++) begin a[j] = (j == 1) ? 3 : 0; e[j] = (j % 2 == 1) ? -3 : 3; end
        tbl[4] = '{1'b0, pk12(a), pk16(e)};
        for (int j = 0; j < 16; j++) begin a[j] = 1; e[j] = (j == 0) ? 1 : 0; end
        tbl[5] = '{1'b1, pk12(a), pk16(e)};
        for (int j = 0; j < 16; j++) begin a[j] = (j == 0) ? -1 : 0; e[j] = -1; end
        tbl[6] = '{1'b1, pk12(a), pk16(e)};
        for (int j = 0; j < 16; j++) begin
            a[j] = (j == 3) ? 7 : 0;
            e[j] = (((j & 1) ^ ((j >> 1) & 1)) != 0) ? -7 : 7;
        end
        tbl[7] = '{1'b0, pk12(a), pk16(e)};

        #12;
        check("reset_busy", {254'd0, busy4, busy2}, 256'd0);
        check("reset_done", {254'd0, done4, done2}, 256'd0);
        check("reset_err", {254'd0, err4, err2}, 256'd0);
        check("reset_out4", o4, 256'd0);
        check("reset_out2", {200'd0, o2}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 4-point: (1,2,3,4) -> (10,-2,-4,0), Done on the third edge
        @(negedge clk);
        s2 = 1'b1;
        in2 = {12'd4, 12'd3, 12'd2, 12'd1};
        @(posedge clk); #1; s2 = 1'b0; in2 = '0;
        check("l2_e0_busy_done", {254'd0, busy2, done2}, 256'd2);
        @(posedge clk); #1;
        check("l2_e1_busy_done", {254'd0, busy2, done2}, 256'd2);
        @(posedge clk); #1;
        check("l2_e2_busy_done", {254'd0, busy2, done2}, 256'd1);
        check("l2_out", {200'd0, o2}, {200'd0, 14'h0000, 14'h3ffc, 14'h3ffe, 14'd10});
        @(posedge clk); #1;
        check("l2_done_pulse", {255'd0, done2}, 256'd0);
        check("l2_out_held", {200'd0, o2}, {200'd0, 14'h0000, 14'h3ffc, 14'h3ffe, 14'd10});

        // 16-point table
        for (int v = 0; v < 8; v++) begin
            start4(tbl[v].inv, tbl[v].in_bus);
            wait4(ed);
            check($sformatf("vec%0d_latency", v), 256'(ed), 256'd4);
            check($sformatf("vec%0d_out", v), o4, tbl[v].exp_bus);
        end

        // Start while busy is ignored and flagged once
        start4(1'b0, bus_ones);
        @(posedge clk); #1;
        @(negedge clk);
        s4 = 1'b1; in4 = bus_imp;
        @(posedge clk); #1;
        s4 = 1'b0;
        check("collide_err_set", {255'd0, err4}, 256'd1);
        @(posedge clk); #1;
        check("collide_err_clr", {254'd0, err4, done4}, 256'd0);
        @(posedge clk); #1;
        check("collide_done", {255'd0, done4}, 256'd1);
        check("collide_out", o4, exp_ones);
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done4) extra++;
        end
        check("collide_no_second_done", 256'(extra), 256'd0);

        // Back-to-back: Start in the Done cycle
        start4(1'b0, bus_imp);
        wait4(ed);
        check("b2b_first_latency", 256'(ed), 256'd4);
        s4 = 1'b1; i4 = 1'b0; in4 = bus_ones;
        @(posedge clk); #1;
        s4 = 1'b0;
        check("b2b_accept", {253'd0, busy4, done4, err4}, 256'd4);
        check("b2b_out_held", o4, exp_imp);
        wait4(ed);
        check("b2b_second_latency", 256'(ed), 256'd4);
        check("b2b_second_out", o4, exp_ones);
        check("b2b_no_err", {255'd0, err4}, 256'd0);

        // Asynchronous reset mid-transform
        start4(1'b0, bus_imp);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl", {253'd0, busy4, done4, err4}, 256'd0);
        check("arst_out", o4, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start4(1'b0, bus_ones);
        wait4(ed);
        check("arst_restart_latency", 256'(ed), 256'd4);
        check("arst_restart_out", o4, exp_ones);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
